tdm_mult_scheduler: RTL
=======================

# tdm_mult_scheduler

Time-division-multiplexed scheduler that shares one pipelined unsigned multiplier among NCH burst-FIFO read channels. Sits in the read-clock domain, downstream of the burst FIFOs' `dout`. It arbitrates channel requests round-robin with burst ownership, so a FIFO burst streams uninterrupted up to a cap. It issues operands into the multiplier pipeline and returns channel-tagged products.

## Interface
- `NCH`, 4: number of requesting channels (2..8)
- `WIDTH`, 8: operand width
- `MULT_LAT`, 3: multiplier pipeline depth in cycles (1..6)
- `BURST_MAX`, 16: maximum consecutive grants to one owner (≥1)

- `rd_clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `req`  in  NCH  per-channel request; channel holds operands stable while `req` is high and `gnt` is low
- `a`  in  NCH*WIDTH  operand A, channel i at bits [i*WIDTH +: WIDTH]
- `b`  in  NCH*WIDTH  operand B, same packing
- `gnt`  out  NCH  one-hot grant, combinational from `req` and registered state; a transfer occurs on an edge where `gnt[i] & req[i]`
- `busy`  out  1  registered; high while state is OWN
- `res_valid`  out  1  product valid strobe
- `res_ch`  out  $clog2(NCH)  channel index of the product
- `res_data`  out  2*WIDTH  unsigned product a*b

## Operation
- Registered state: `state` ∈ {IDLE, OWN}, `owner`, `ptr` (round-robin pointer), and `beat_cnt`, $clog2(BURST_MAX+1) bits.
- Candidate selection: the first set `req` bit scanning from `ptr` upward, wrapping NCH-1→0.
- IDLE:
  - `req`==0: `gnt`=0, stay in IDLE.
  - Otherwise: grant the candidate, then `owner`←cand, `beat_cnt`←1, go to OWN.
- OWN, continue: `req[owner]` high and `beat_cnt` < BURST_MAX. Grant `owner`; `beat_cnt`++.
- OWN, end of burst: `req[owner]` low, or `beat_cnt`==BURST_MAX.
  - `ptr`←owner+1 (mod NCH), used for selection in the same cycle.
  - Select from `req` with the owner excluded. If no other channel requests, the owner may be selected.
  - Candidate found: grant it, `owner`←cand, `beat_cnt`←1, stay in OWN.
  - No candidate: `gnt`=0, go to IDLE.
- At most one `gnt` bit is ever high. `gnt[i]` is never high while `req[i]` is low.
- Issue: on a transfer edge, operands of the granted channel and its index enter pipeline stage 0 with a valid bit. Non-transfer cycles insert a bubble (valid=0).
- Products are full 2*WIDTH unsigned, with no truncation or saturation.
- No output backpressure: every issued operation produces exactly one `res_valid` pulse, in issue order.

## Timing
- `gnt` is combinational in the same cycle as `req`. Grant decision to transfer takes 0 cycles.
- Latency: a transfer at edge N gives `res_valid`=1 with matching `res_ch`/`res_data` registered after edge N+MULT_LAT.
- Throughput: one operation per cycle. A burst switch incurs no bubble when another channel is requesting.
- Reset values: state=IDLE, `ptr`=0, `owner`=0, `beat_cnt`=0, all pipeline valids=0, `res_valid`=0, `res_ch`=0, `res_data`=0, `busy`=0. `gnt`=0 whenever `rst` is high.
- Reset mid-operation:
  - In-flight pipeline entries are discarded; no `res_valid` after the `rst` edge.
  - Arbitration restarts from channel 0 on the first cycle after `rst` deasserts.
- `res_data`/`res_ch` hold their last value when `res_valid`=0.
- BURST_MAX=1 degenerates to pure per-beat round-robin.
- Owner drops `req` in the same cycle another channel raises `req`: the other channel is granted that cycle.

## Test plan
- Reset check: hold `rst` 3 cycles with `req`=4'b1111. Required: `gnt`=0, `res_valid`=0 throughout. First grant after release is ch0.
- Single burst: ch2 requests 5 beats with a=3, b=1..5. Required: `gnt`=4'b0100 for 5 cycles, then IDLE. `res_valid` runs 3 cycles later with `res_data`=3,6,9,12,15 and `res_ch`=2.
- Burst cap: ch0 and ch1 request continuously, BURST_MAX=16. Required: 16 grants to ch0, 16 to ch1, then ch0, with no bubble cycles.
- Cap with lone requester: only ch3 requests, for 20 beats. Required: ch3 granted 20 consecutive cycles, and the burst restart at beat 17 has no gap.
- Max operands: a=b=8'hFF on ch1. Required: `res_data`=16'hFE01, `res_ch`=1.
- Reset mid-stream: assert `rst` while 3 operations are in flight. Required: none of the 3 produce `res_valid`, and `ptr` restarts at 0.

Source files
------------

// File: rtl/tdm_mult_scheduler.sv
// Round-robin, burst-owning arbiter that time-shares one pipelined unsigned
// multiplier among NCH FIFO read channels and returns channel-tagged products.
module tdm_mult_scheduler #(
  parameter int  NCH       = 4,
  parameter int  WIDTH     = 8,
  parameter int  MULT_LAT  = 3,
  parameter int  BURST_MAX = 16,
  localparam int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 rd_clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       req,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic [NCH*WIDTH-1:0] b,
  output logic [NCH-1:0]       gnt,
  output logic                 busy,
  output logic                 res_valid,
  output logic [CHW-1:0]       res_ch,
  output logic [2*WIDTH-1:0]   res_data
);
  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int PW = 2 * WIDTH;

  typedef enum logic {S_IDLE, S_OWN} state_t;

  state_t         state_q, state_d;
  logic [CHW-1:0] owner_q, owner_d;
  logic [CHW-1:0] ptr_q, ptr_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [CHW-1:0] gidx;
  logic [CHW-1:0] owner_nxt;
  logic [NCH-1:0] others;
  logic [NCH-1:0] pool;
  logic           issue;

  function automatic logic [CHW-1:0] rr_pick(input logic [NCH-1:0] m,
                                             input logic [CHW-1:0] p);
    logic [CHW-1:0] r;
    logic           hit;
    int             idx;
    r   = '0;
    hit = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(p) + k) % NCH;
      if (!hit && m[idx]) begin
        r   = CHW'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [CHW-1:0] inc_mod(input logic [CHW-1:0] v);
    return (int'(v) == NCH - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    gidx       = owner_q;
    issue      = 1'b0;
    owner_nxt  = inc_mod(owner_q);
    others     = req;
    others[owner_q] = 1'b0;
    // The retiring owner only wins again when nobody else is asking.
    pool       = (|others) ? others : req;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          gidx       = rr_pick(req, ptr_q);
          issue      = 1'b1;
          owner_d    = gidx;
          beat_cnt_d = BW'(1);
          state_d    = S_OWN;
        end
      end
      S_OWN: begin
        if (req[owner_q] && (beat_cnt_q < BW'(BURST_MAX))) begin
          issue      = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else begin
          ptr_d = owner_nxt;
          if (|pool) begin
            gidx       = rr_pick(pool, owner_nxt);
            issue      = 1'b1;
            owner_d    = gidx;
            beat_cnt_d = BW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) issue = 1'b0;
    gnt = '0;
    if (issue) gnt[gidx] = 1'b1;
  end

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= '0;
      ptr_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign busy = (state_q == S_OWN);

  logic [WIDTH-1:0] a_p0_q, b_p0_q;
  logic [PW-1:0]    mult_p0;
  logic             vld_q  [0:MULT_LAT];
  logic [CHW-1:0]   ch_q   [0:MULT_LAT];
  logic [PW-1:0]    prod_q [1:MULT_LAT];
  logic [PW-1:0]    prod_d [1:MULT_LAT];

  // Stage 0: operands of the granted channel; bubbles carry don't-care data.
  always_ff @(posedge rd_clk) begin
    a_p0_q  <= a[int'(gidx)*WIDTH +: WIDTH];
    b_p0_q  <= b[int'(gidx)*WIDTH +: WIDTH];
    ch_q[0] <= gidx;
  end

  assign mult_p0 = PW'(a_p0_q) * PW'(b_p0_q);

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      for (int k = 0; k <= MULT_LAT; k++) vld_q[k] <= 1'b0;
    end else begin
      vld_q[0] <= issue;
      for (int k = 1; k <= MULT_LAT; k++) vld_q[k] <= vld_q[k-1];
    end
  end

  // Stages 1..MULT_LAT: product pipeline; the last stage is the held output.
  for (genvar k = 1; k <= MULT_LAT; k++) begin : g_stage
    if (k == 1) begin : g_first
      assign prod_d[k] = mult_p0;
    end else begin : g_next
      assign prod_d[k] = prod_q[k-1];
    end
    if (k < MULT_LAT) begin : g_mid
      always_ff @(posedge rd_clk) begin
        prod_q[k] <= prod_d[k];
        ch_q[k]   <= ch_q[k-1];
      end
    end else begin : g_out
      always_ff @(posedge rd_clk) begin
        if (rst) begin
          prod_q[k] <= '0;
          ch_q[k]   <= '0;
        end else if (vld_q[k-1]) begin
          prod_q[k] <= prod_d[k];
          ch_q[k]   <= ch_q[k-1];
        end
      end
    end
  end

  assign res_valid = vld_q[MULT_LAT];
  assign res_ch    = ch_q[MULT_LAT];
  assign res_data  = prod_q[MULT_LAT];

endmodule
